// File: rtl/cache_pkg.sv
// Shared types, sizes and address-split helpers for the direct-mapped data cache.
package cache_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned OFFSET_W   = 4;
    localparam int unsigned WORD_SEL_W = $clog2(LINE_WORDS);
    localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WB_REQ,
        ALLOC_REQ,
        ALLOC_WAIT
    } state_t;

    // Request captured at accept; held for the whole miss sequence.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              is_store;
        logic [WORD_W-1:0] data;
    } req_t;

    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return WORD_SEL_W'(a >> 2);
    endfunction

    // Index and tag are returned zero-extended; callers narrow them to their widths.
    function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] a,
                                                     input int unsigned index_w);
        return (a >> OFFSET_W) & ((ADDR_W'(1) << index_w) - ADDR_W'(1));
    endfunction

    function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] a,
                                                   input int unsigned index_w);
        return a >> (OFFSET_W + index_w);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/dirty/tag/data storage: async read, sync store or line fill, async flag clear.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned INDEX_W  = $clog2(NUM_SETS),
    parameter int unsigned TAG_W    = ADDR_W - OFFSET_W - INDEX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_W-1:0]    index,
    output logic                  valid,
    output logic                  dirty,
    output logic [TAG_W-1:0]      tag,
    output logic [LINE_W-1:0]     line,
    input  logic                  store_en,
    input  logic [WORD_SEL_W-1:0] store_word,
    input  logic [WORD_W-1:0]     store_data,
    input  logic                  fill_en,
    input  logic [TAG_W-1:0]      fill_tag,
    input  logic [LINE_W-1:0]     fill_data
);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [WORD_W-1:0]   data_mem [NUM_SETS][LINE_WORDS];

    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_mem[index];

    always_comb begin
        line = '0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            line[w*WORD_W +: WORD_W] = data_mem[index][w];
        end
    end

    // Only the state flags are reset; tag/data contents are don't-care while invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (store_en) begin
            dirty_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[index] <= fill_tag;
            for (int w = 0; w < LINE_WORDS; w++) begin
                data_mem[index][w] <= fill_data[w*WORD_W +: WORD_W];
            end
        end else if (store_en) begin
            data_mem[index][store_word] <= store_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
module data_cache
    import cache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              is_input_valid,
    output logic              is_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] din,
    output logic              is_output_valid,
    output logic [WORD_W-1:0] dout,
    output logic              is_hit,
    output logic              mem_req_valid,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_data,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_data,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int unsigned INDEX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W   = ADDR_W - OFFSET_W - INDEX_W;

    state_t              state, state_next;
    req_t                req;
    logic                first_lookup;
    logic [WORD_W-1:0]   dout_q;

    logic [INDEX_W-1:0]    req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [WORD_SEL_W-1:0] req_word;
    logic                  line_valid, line_dirty, hit, accept;
    logic [TAG_W-1:0]      line_tag;
    logic [LINE_W-1:0]     line_data;
    logic                  store_en, fill_en;

    assign req_index = INDEX_W'(addr_index(req.addr, INDEX_W));
    assign req_tag   = TAG_W'(addr_tag(req.addr, INDEX_W));
    assign req_word  = addr_word(req.addr);
    assign hit       = line_valid && (line_tag == req_tag);
    assign accept    = (state == IDLE) && is_input_valid && (mem_read || mem_write);

    cache_line_array #(
        .NUM_SETS (NUM_SETS),
        .INDEX_W  (INDEX_W),
        .TAG_W    (TAG_W)
    ) u_lines (
        .clk        (clk),
        .reset      (reset),
        .index      (req_index),
        .valid      (line_valid),
        .dirty      (line_dirty),
        .tag        (line_tag),
        .line       (line_data),
        .store_en   (store_en),
        .store_word (req_word),
        .store_data (req.data),
        .fill_en    (fill_en),
        .fill_tag   (req_tag),
        .fill_data  (mem_resp_data)
    );

    // Next state and handshake outputs; completion is signalled in COMPARE itself.
    always_comb begin
        state_next      = state;
        is_ready        = 1'b0;
        is_output_valid = 1'b0;
        is_hit          = 1'b0;
        dout            = dout_q;
        mem_req_valid   = 1'b0;
        mem_req_write   = 1'b0;
        mem_req_addr    = '0;
        mem_req_data    = '0;
        store_en        = 1'b0;
        fill_en         = 1'b0;
        case (state)
            IDLE: begin
                is_ready = 1'b1;
                if (accept) state_next = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    is_output_valid = 1'b1;
                    is_hit          = first_lookup;
                    if (req.is_store) store_en = 1'b1;
                    else              dout = line_data[32'(req_word) * WORD_W +: WORD_W];
                    state_next = IDLE;
                end else if (line_dirty) begin
                    state_next = WB_REQ;
                end else begin
                    state_next = ALLOC_REQ;
                end
            end
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {line_tag, req_index, OFFSET_W'(0)};
                mem_req_data  = line_data;
                if (mem_req_ready) state_next = ALLOC_REQ;
            end
            ALLOC_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_index, OFFSET_W'(0)};
                if (mem_req_ready) state_next = ALLOC_WAIT;
            end
            ALLOC_WAIT: begin
                if (mem_resp_valid) begin
                    fill_en    = 1'b1;
                    state_next = COMPARE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            req          <= '0;
            first_lookup <= 1'b0;
            dout_q       <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            state  <= state_next;
            dout_q <= dout;
            if (accept) begin
                req.addr     <= addr;
                req.is_store <= mem_write;
                req.data     <= din;
                first_lookup <= 1'b1;
            end else if (state == COMPARE) begin
                first_lookup <= 1'b0;
            end
            // Only the first lookup of a request is counted; both counters saturate.
            if (state == COMPARE && first_lookup) begin
                if (hit && hit_count != '1)        hit_count  <= hit_count + 32'd1;
                else if (!hit && miss_count != '1) miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule
